// File: rtl/headgen_pipe_ctrl.sv
// Sequences a STAGES-deep header pipeline that emits NUM_WORDS words per accepted request.
// First word reaches the output STAGES cycles after the first ISSUE cycle; out_ready=0 with out_valid=1 freezes every stage.
module headgen_pipe_ctrl #(
    parameter int STAGES    = 3,
    parameter int NUM_WORDS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [15:0]       req_len,
    output logic              ack,
    output logic              busy,
    output logic [15:0]       len_q,
    output logic [7:0]        word_idx,
    output logic [STAGES-1:0] stage_en,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] lst;
    logic              advance;
    logic              accept;
    logic              issue_last;
    logic              vld_in;
    logic              lst_in;

    // All stages share one enable so a stall holds the whole pipeline in place.
    assign advance    = ~out_valid | out_ready;
    assign stage_en   = {STAGES{advance}};
    assign out_valid  = vld[STAGES-1];
    assign out_last   = lst[STAGES-1];
    assign busy       = (state != IDLE);
    assign issue_last = (word_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        vld_in    = 1'b0;
        lst_in    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                vld_in = 1'b1;
                lst_in = issue_last;
                if (advance && issue_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack      <= 1'b0;
            len_q    <= 16'd0;
            word_idx <= 8'd0;
            vld      <= '0;
            lst      <= '0;
        end else begin
            ack <= accept;
            if (accept) begin
                len_q    <= req_len;
                word_idx <= 8'd0;
            end else if (state == ISSUE && advance && !issue_last) begin
                word_idx <= word_idx + 8'd1;
            end
            // DRAIN feeds bubbles (valid=0, last=0) behind the final word.
            if (advance) begin
                vld[0] <= vld_in;
                lst[0] <= lst_in;
                for (int i = 1; i < STAGES; i++) begin
                    vld[i] <= vld[i-1];
                    lst[i] <= lst[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_headgen_pipe_ctrl.sv
// Bench for headgen_pipe_ctrl: two instances (4-word and 1-word) share stimulus and are
// compared every cycle against an advance-counting transaction model plus directed literal checks.
module tb_headgen_pipe_ctrl;

    localparam int SA = 3;
    localparam int NA = 4;
    localparam int NB = 1;

    typedef struct packed {
        logic        busy;
        logic        ack;
        logic [15:0] len;
        int          a;
        int          widx;
    } model_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [15:0] req_len;
    logic        out_ready;

    logic          a_ack, a_busy, a_ov, a_ol;
    logic [15:0]   a_len;
    logic [7:0]    a_widx;
    logic [SA-1:0] a_en;
    logic          b_ack, b_busy, b_ov, b_ol;
    logic [15:0]   b_len;
    logic [7:0]    b_widx;
    logic [SA-1:0] b_en;

    model_t ma = '0;
    model_t mb = '0;
    int n_chk = 0;
    int n_err = 0;
    int hs_a  = 0;
    int hs_b  = 0;

    headgen_pipe_ctrl #(.STAGES(SA), .NUM_WORDS(NA)) dut_a (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len),
        .ack(a_ack), .busy(a_busy), .len_q(a_len), .word_idx(a_widx),
        .stage_en(a_en), .out_valid(a_ov), .out_last(a_ol), .out_ready(out_ready)
    );

    headgen_pipe_ctrl #(.STAGES(SA), .NUM_WORDS(NB)) dut_b (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len),
        .ack(b_ack), .busy(b_busy), .len_q(b_len), .word_idx(b_widx),
        .stage_en(b_en), .out_valid(b_ov), .out_last(b_ol), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Model: 'a' counts pipeline advances since acceptance; word k sits at the output when a == k + stages.
    function automatic logic mvalid(model_t m, int s, int nw);
        int pos;
        pos = m.a - s;
        return m.busy && pos >= 0 && pos < nw;
    endfunction

    function automatic model_t step(model_t m, int s, int nw, logic rq, logic [15:0] ln, logic rdy);
        model_t n;
        logic   v;
        n     = m;
        v     = mvalid(m, s, nw);
        n.ack = 1'b0;
        if (!m.busy) begin
            if (rq) begin
                n.busy = 1'b1;
                n.ack  = 1'b1;
                n.len  = ln;
                n.a    = 0;
                n.widx = 0;
            end
        end else if (v && rdy && (m.a - s == nw - 1)) begin
            n.busy = 1'b0;
        end else if (!v || rdy) begin
            n.a    = m.a + 1;
            n.widx = (n.a < nw - 1) ? n.a : nw - 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, SA, NA, req, req_len, out_ready);
            mb <= step(mb, SA, NB, req, req_len, out_ready);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_dut(string t, model_t m, int s, int nw, logic ak, logic bz, logic [15:0] ln,
                           logic [7:0] wi, logic [SA-1:0] en, logic ov, logic ol);
        logic v;
        v = mvalid(m, s, nw);
        chk({t, ".ack"},       32'(ak), 32'(m.ack));
        chk({t, ".busy"},      32'(bz), 32'(m.busy));
        chk({t, ".len_q"},     32'(ln), 32'(m.len));
        chk({t, ".word_idx"},  32'(wi), 32'(m.widx));
        chk({t, ".out_valid"}, 32'(ov), 32'(v));
        chk({t, ".stage_en"},  32'(en), (v && !out_ready) ? 32'd0 : 32'd7);
        if (v) chk({t, ".out_last"}, 32'(ol), 32'(m.a - s == nw - 1));
    endtask

    // Inputs set after a tick apply to the next rising edge, so handshakes are counted before waiting.
    task automatic tick();
        hs_a += int'(a_ov && out_ready);
        hs_b += int'(b_ov && out_ready);
        @(negedge clk);
        cmp_dut("a", ma, SA, NA, a_ack, a_busy, a_len, a_widx, a_en, a_ov, a_ol);
        cmp_dut("b", mb, SA, NB, b_ack, b_busy, b_len, b_widx, b_en, b_ov, b_ol);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, want $finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] cv_ack, cv_ov, cv_ol, cv_busy;
        logic [4:0]  st_ov, st_ol;
        int wbad, n_ack, fall, ack2, ack_before, ov_seen;

        rst = 1'b0; req = 1'b0; req_len = 16'd0; out_ready = 1'b1;
        tick();
        chk("rst.busy",     32'(a_busy), 32'd0);
        chk("rst.ack",      32'(a_ack),  32'd0);
        chk("rst.len_q",    32'(a_len),  32'd0);
        chk("rst.word_idx", 32'(a_widx), 32'd0);
        chk("rst.out_valid",32'(a_ov),   32'd0);
        chk("rst.out_last", 32'(a_ol),   32'd0);
        chk("rst.stage_en", 32'(a_en),   32'd7);
        chk("rst.b_stage_en", 32'(b_en), 32'd7);
        rst = 1'b1;
        tick();
        tick();

        // Plain request, no stalls.
        req = 1'b1; req_len = 16'h05DC;
        for (int k = 0; k < 12; k++) begin
            tick();
            cv_ack[k] = a_ack; cv_ov[k] = a_ov; cv_ol[k] = a_ol; cv_busy[k] = a_busy;
            if (k == 0) begin
                req = 1'b0;
                chk("s2.len_q", 32'(a_len), 32'h05DC);
            end
        end
        chk("s2.ack_pulse",  32'(cv_ack),  32'h001);
        chk("s2.out_valid",  32'(cv_ov),   32'h078);
        chk("s2.out_last",   32'(cv_ol),   32'h040);
        chk("s2.busy",       32'(cv_busy), 32'h07F);

        // Five stalled edges while word 1 is at the output.
        req = 1'b1; hs_a = 0; wbad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 0) req = 1'b0;
            if (k >= 5 && k <= 9) begin
                st_ov[k-5] = a_ov;
                st_ol[k-5] = a_ol;
                if (a_widx != 8'd3) wbad++;
            end
            if (k == 4) out_ready = 1'b0;
            if (k == 9) out_ready = 1'b1;
        end
        chk("s3.stall_out_valid", 32'(st_ov), 32'h1F);
        chk("s3.stall_out_last",  32'(st_ol), 32'h00);
        chk("s3.stall_word_idx",  32'(wbad),  32'd0);
        chk("s3.handshakes",      32'(hs_a),  32'd4);

        // req held high across two requests.
        req = 1'b1; req_len = 16'hFFFF;
        n_ack = 0; fall = -1; ack2 = -1; ack_before = 0;
        for (int k = 0; k < 60 && ack2 < 0; k++) begin
            tick();
            if (a_ack) begin
                n_ack++;
                if (n_ack == 2) ack2 = k;
            end
            if (!a_busy && fall < 0) begin
                fall = k;
                ack_before = n_ack;
            end
        end
        req = 1'b0;
        chk("s4.acks",            32'(n_ack),          32'd2);
        chk("s4.acks_while_busy", 32'(ack_before),     32'd1);
        chk("s4.ack_gap",         32'(ack2 - fall + 1),32'd2);
        chk("s4.len_q",           32'(a_len),          32'hFFFF);
        for (int k = 0; k < 15; k++) tick();

        // Single-word instance, zero length.
        req = 1'b1; req_len = 16'h0000; hs_b = 0; wbad = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 0) begin
                req = 1'b0;
                chk("s5.len_q", 32'(b_len), 32'd0);
            end
            if (k < 8) begin
                cv_ack[k] = b_ack; cv_ov[k] = b_ov; cv_ol[k] = b_ol; cv_busy[k] = b_busy;
            end
            if (b_widx != 8'd0) wbad++;
        end
        chk("s5.ack_pulse",  32'(cv_ack[7:0]),  32'h01);
        chk("s5.out_valid",  32'(cv_ov[7:0]),   32'h08);
        chk("s5.out_last",   32'(cv_ol[7:0]),   32'h08);
        chk("s5.busy",       32'(cv_busy[7:0]), 32'h0F);
        chk("s5.word_idx",   32'(wbad),         32'd0);
        chk("s5.handshakes", 32'(hs_b),         32'd1);

        // Asynchronous reset while the first word is at the output.
        req = 1'b1; req_len = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) req = 1'b0;
        end
        chk("s1.pre_out_valid", 32'(a_ov),   32'd1);
        chk("s1.pre_busy",      32'(a_busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("s1.async_out_valid", 32'(a_ov),   32'd0);
        chk("s1.async_busy",      32'(a_busy), 32'd0);
        chk("s1.async_ack",       32'(a_ack),  32'd0);
        chk("s1.async_len_q",     32'(a_len),  32'd0);
        chk("s1.async_b_valid",   32'(b_ov),   32'd0);
        req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("s1.no_ack_in_reset", 32'(a_ack | b_ack), 32'd0);
        end
        req = 1'b0; rst = 1'b1; ov_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            ov_seen += int'(a_ov) + int'(b_ov);
        end
        chk("s1.no_words_after_reset", 32'(ov_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
